// File: rtl/wb_periph_fabric_pkg.sv
// Shared types and constants for the Wishbone peripheral fabric.
// Covers the FSM state encoding, error data patterns and status-register offsets.
package wb_periph_fabric_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int IDX_W = 4;

  localparam logic [31:0] ERR_UNMAPPED = 32'hDEAD_0ADD;
  localparam logic [31:0] ERR_TIMEOUT  = 32'hBADC_0FFE;

  localparam logic [1:0] STAT_OFF_FLAGS = 2'd0;
  localparam logic [1:0] STAT_OFF_ADDR  = 2'd1;

  function automatic logic [31:0] status_word(input logic [15:0] cnt, input logic [1:0] flags);
    return {cnt, 14'b0, flags};
  endfunction

endpackage

// File: rtl/wb_page_decode.sv
// Combinational page decoder: maps wbs_adr_i[31:12] to a slave index,
// a status-page hit, or neither (unmapped).
module wb_page_decode
  import wb_periph_fabric_pkg::*;
#(
  parameter int          NSLV      = 8,
  parameter logic [19:0] BASE_PAGE = 20'h30001,
  parameter logic [19:0] STAT_PAGE = 20'h30000
) (
  input  logic [19:0]      page_i,
  output logic             hit_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             stat_hit_o
);

  logic [19:0] offset;

  always_comb begin
    offset     = page_i - BASE_PAGE;
    stat_hit_o = (page_i == STAT_PAGE);
    // Wrap-around subtraction makes pages below BASE_PAGE look huge, so one compare covers both ends.
    hit_o      = !stat_hit_o && (offset < 20'(NSLV));
    idx_o      = offset[IDX_W-1:0];
  end

endmodule

// File: rtl/wb_periph_fabric.sv
// Wishbone fabric: one master port fanned out to NSLV slaves on consecutive 4 KB pages,
// with unmapped/timeout error responses and a status page.
//
// state | meaning
// IDLE  | waiting for cyc&stb; decodes page, handles status/unmapped at once
// BUSY  | strobing the selected slave, counting down the timeout
// RESP  | result latched; ack and data registered out next cycle
module wb_periph_fabric
  import wb_periph_fabric_pkg::*;
#(
  parameter int          NSLV      = 8,
  parameter logic [19:0] BASE_PAGE = 20'h30001,
  parameter logic [19:0] STAT_PAGE = 20'h30000,
  parameter int          TMO_W     = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  output logic [NSLV-1:0]      s_stb_o,
  input  logic [NSLV-1:0]      s_ack_i,
  input  logic [32*NSLV-1:0]   s_dat_i,
  output logic                 err_irq_o
);

  // Down-counter spans 2**TMO_W-1 BUSY cycles: loaded value down to zero inclusive.
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'((1 << TMO_W) - 2);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             we_q, we_d;
  logic [31:0]      adr_q, adr_d;
  logic [NSLV-1:0]  stb_q, stb_d;
  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic [15:0]      err_cnt_q, err_cnt_d;
  logic [1:0]       err_flags_q, err_flags_d;
  logic [31:0]      err_addr_q, err_addr_d;

  logic             dec_hit, dec_stat_hit;
  logic [IDX_W-1:0] dec_idx;
  logic             sel_ack;
  logic [31:0]      sel_dat;
  logic             log_unmapped, log_tmo, stat_clr;

  wb_page_decode #(
    .NSLV      (NSLV),
    .BASE_PAGE (BASE_PAGE),
    .STAT_PAGE (STAT_PAGE)
  ) u_decode (
    .page_i     (wbs_adr_i[31:12]),
    .hit_o      (dec_hit),
    .idx_o      (dec_idx),
    .stat_hit_o (dec_stat_hit)
  );

  always_comb begin
    sel_ack = 1'b0;
    sel_dat = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_ack = s_ack_i[k];
        sel_dat = s_dat_i[32*k +: 32];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tmo_d        = tmo_q;
    rdata_d      = rdata_q;
    we_d         = we_q;
    adr_d        = adr_q;
    stb_d        = stb_q;
    ack_d        = 1'b0;
    dat_d        = '0;
    err_cnt_d    = err_cnt_q;
    err_flags_d  = err_flags_q;
    err_addr_d   = err_addr_q;
    log_unmapped = 1'b0;
    log_tmo      = 1'b0;
    stat_clr     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // ack_q high means the master still holds stb for the access just answered.
        if (wbs_cyc_i && wbs_stb_i && !ack_q) begin
          adr_d = wbs_adr_i;
          we_d  = wbs_we_i;
          if (dec_stat_hit) begin
            state_d = ST_RESP;
            if (wbs_we_i) begin
              rdata_d  = '0;
              stat_clr = (wbs_adr_i[3:2] == STAT_OFF_FLAGS);
            end else begin
              case (wbs_adr_i[3:2])
                STAT_OFF_FLAGS: rdata_d = status_word(err_cnt_q, err_flags_q);
                STAT_OFF_ADDR:  rdata_d = err_addr_q;
                default:        rdata_d = '0;
              endcase
            end
          end else if (dec_hit) begin
            idx_d   = dec_idx;
            tmo_d   = TMO_LOAD;
            state_d = ST_BUSY;
            for (int k = 0; k < NSLV; k++) stb_d[k] = (dec_idx == IDX_W'(k));
          end else begin
            rdata_d      = ERR_UNMAPPED;
            log_unmapped = 1'b1;
            state_d      = ST_RESP;
          end
        end
      end
      ST_BUSY: begin
        if (!wbs_cyc_i) begin
          stb_d   = '0;
          state_d = ST_IDLE;
        end else if (sel_ack) begin
          rdata_d = sel_dat;
          stb_d   = '0;
          state_d = ST_RESP;
        end else if (tmo_q == '0) begin
          rdata_d = ERR_TIMEOUT;
          log_tmo = 1'b1;
          stb_d   = '0;
          state_d = ST_RESP;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      ST_RESP: begin
        ack_d   = 1'b1;
        dat_d   = we_q ? 32'h0 : rdata_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (stat_clr) begin
      err_cnt_d   = '0;
      err_flags_d = '0;
    end else if (log_unmapped || log_tmo) begin
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      err_flags_d = err_flags_q | {log_tmo, log_unmapped};
      err_addr_d  = log_tmo ? adr_q : wbs_adr_i;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      tmo_q       <= '0;
      rdata_q     <= '0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      stb_q       <= '0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      err_cnt_q   <= '0;
      err_flags_q <= '0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      rdata_q     <= rdata_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      stb_q       <= stb_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      err_cnt_q   <= err_cnt_d;
      err_flags_q <= err_flags_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign s_stb_o   = stb_q;
  assign err_irq_o = (err_cnt_q != 16'd0);

endmodule

// File: tb/tb_wb_periph_fabric.sv
// Self-checking bench for wb_periph_fabric: directed scenarios plus a randomized mix,
// checked against a transaction-level model of results, latencies and error status.
module tb_wb_periph_fabric;
  localparam int          NSLV      = 8;
  localparam int          TMO_W     = 4;
  localparam logic [19:0] BASE_PAGE = 20'h30001;
  localparam logic [19:0] STAT_PAGE = 20'h30000;
  localparam int          NEVER     = 1000;
  localparam int          TMO_CYC   = (1 << TMO_W) - 1;

  logic                wb_clk_i   = 1'b0;
  logic                wb_rst_n_i = 1'b0;
  logic                wbs_cyc_i  = 1'b0;
  logic                wbs_stb_i  = 1'b0;
  logic                wbs_we_i   = 1'b0;
  logic [31:0]         wbs_adr_i  = '0;
  logic [31:0]         wbs_dat_i  = '0;
  logic                wbs_ack_o;
  logic [31:0]         wbs_dat_o;
  logic [NSLV-1:0]     s_stb_o;
  logic [NSLV-1:0]     s_ack_i    = '0;
  logic [32*NSLV-1:0]  s_dat_i;
  logic                err_irq_o;

  int checks = 0;
  int errors = 0;

  int          slv_delay[NSLV];
  logic [31:0] slv_data[NSLV];
  int          slv_cnt[NSLV];
  logic [NSLV-1:0] stray_mask = '0;

  logic [15:0] m_cnt;
  logic [1:0]  m_flags;
  logic [31:0] m_addr;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_periph_fabric #(
    .NSLV      (NSLV),
    .BASE_PAGE (BASE_PAGE),
    .STAT_PAGE (STAT_PAGE),
    .TMO_W     (TMO_W)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_n_i (wb_rst_n_i),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .s_stb_o    (s_stb_o),
    .s_ack_i    (s_ack_i),
    .s_dat_i    (s_dat_i),
    .err_irq_o  (err_irq_o)
  );

  always_comb
    for (int k = 0; k < NSLV; k++) s_dat_i[32*k +: 32] = slv_data[k];

  // Slave responder: acks after slv_delay[k] cycles of seeing its strobe.
  always @(negedge wb_clk_i) begin
    logic [NSLV-1:0] acks;
    acks = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (s_stb_o[k]) begin
        acks[k] = (slv_cnt[k] == slv_delay[k]);
        slv_cnt[k]++;
      end else begin
        slv_cnt[k] = 0;
      end
    end
    s_ack_i = acks | stray_mask;
  end

  // Protocol monitor: ack is single-cycle, data is zero without ack, strobes one-hot or zero.
  logic prev_ack = 1'b0;
  always @(negedge wb_clk_i) begin
    if (wb_rst_n_i) begin
      checks++;
      if (wbs_ack_o && prev_ack) begin
        errors++;
        $display("FAIL ack_width: ack high two cycles in a row at %0t", $time);
      end
      if (!wbs_ack_o && wbs_dat_o !== 32'h0) begin
        errors++;
        $display("FAIL dat_idle: wbs_dat_o=%h required 0 without ack at %0t", wbs_dat_o, $time);
      end
      if ($countones(s_stb_o) > 1) begin
        errors++;
        $display("FAIL stb_onehot: s_stb_o=%b at %0t", s_stb_o, $time);
      end
    end
    prev_ack = wbs_ack_o;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_log(input logic [31:0] a);
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    m_addr = a;
  endfunction

  function automatic logic [31:0] model_stat(input logic [1:0] off);
    if (off == 2'd0) return {m_cnt, 14'h0, m_flags};
    if (off == 2'd1) return m_addr;
    return 32'h0;
  endfunction

  function automatic logic [31:0] slave_adr(input int k, input logic [11:0] off);
    logic [19:0] pg;
    pg = BASE_PAGE + 20'(k);
    return {pg, off};
  endfunction

  // One master access; called and returns at posedge+1. lat counts cycles after the stb-sampling edge.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input int sidx,
                      output logic [31:0] rd, output int lat, output int stb_n, output bit stb_bad);
    logic [NSLV-1:0] onehot;
    onehot = '0;
    if (sidx >= 0) onehot[sidx] = 1'b1;
    rd = '0; lat = -1; stb_n = 0; stb_bad = 0;
    wbs_adr_i = a; wbs_we_i = w; wbs_dat_i = d; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge wb_clk_i);
      if (s_stb_o != '0) begin
        if (sidx >= 0 && s_stb_o == onehot) stb_n++;
        else stb_bad = 1;
      end
      if (wbs_ack_o) begin
        rd  = wbs_dat_o;
        lat = n - 1;
        break;
      end
    end
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0 || s_stb_o !== '0 || err_irq_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b dat=%h stb=%b irq=%b required all 0",
               wbs_ack_o, wbs_dat_o, s_stb_o, err_irq_o);
    end
  endtask

  task automatic test_slave_read();
    logic [31:0] rd; int lat, sn; bit sb;
    slv_delay[1] = 0; slv_data[1] = 32'h1234_5678;
    xfer(32'h3000_2010, 1'b0, 32'h0, 1, rd, lat, sn, sb);
    checks++;
    if (rd !== 32'h1234_5678 || lat != 3 || sn != 1 || sb) begin
      errors++;
      $display("FAIL slave1_read: dat=%h lat=%0d stb_cycles=%0d bad=%0d required 1234_5678/3/1/0",
               rd, lat, sn, sb);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd; int lat, sn; bit sb;
    xfer(32'h3009_0000, 1'b0, 32'h0, -1, rd, lat, sn, sb);
    m_flags[0] = 1'b1; model_log(32'h3009_0000);
    checks++;
    if (rd !== 32'hDEAD_0ADD || lat != 2 || sn != 0 || sb) begin
      errors++;
      $display("FAIL unmapped_read: dat=%h lat=%0d stb=%0d/%0d required DEAD0ADD/2/0/0", rd, lat, sn, sb);
    end
    xfer(32'h3000_0000, 1'b0, 32'h0, -1, rd, lat, sn, sb);
    checks++;
    if (rd !== 32'h0001_0001 || lat != 2) begin
      errors++;
      $display("FAIL stat_flags: dat=%h lat=%0d required 00010001/2", rd, lat);
    end
    xfer(32'h3000_0004, 1'b0, 32'h0, -1, rd, lat, sn, sb);
    checks++;
    if (rd !== 32'h3009_0000) begin
      errors++;
      $display("FAIL stat_addr: dat=%h required 30090000", rd);
    end
    checks++;
    if (err_irq_o !== 1'b1) begin
      errors++;
      $display("FAIL irq_set: err_irq_o=%b required 1", err_irq_o);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [31:0] rd; int lat, sn; bit sb;
    slv_delay[5] = NEVER;
    wbs_adr_i = slave_adr(5, 12'h0); wbs_we_i = 1'b0; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    repeat (3) @(posedge wb_clk_i);
    #2 wb_rst_n_i = 1'b0;
    #1;
    checks++;
    if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0 || s_stb_o !== '0 || err_irq_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_busy: ack=%b dat=%h stb=%b irq=%b required all 0",
               wbs_ack_o, wbs_dat_o, s_stb_o, err_irq_o);
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    m_cnt = '0; m_flags = '0; m_addr = '0;
    @(posedge wb_clk_i); #1 wb_rst_n_i = 1'b1;
    @(posedge wb_clk_i); #1;
    xfer(32'h3000_0000, 1'b0, 32'h0, -1, rd, lat, sn, sb);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL reset_clears_stat: dat=%h required 0", rd);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] rd; int lat, sn; bit sb;
    slv_delay[3] = NEVER;
    xfer(slave_adr(3, 12'h0), 1'b0, 32'h0, 3, rd, lat, sn, sb);
    m_flags[1] = 1'b1; model_log(slave_adr(3, 12'h0));
    checks++;
    if (rd !== 32'hBADC_0FFE || sn != TMO_CYC || lat != TMO_CYC + 2 || sb) begin
      errors++;
      $display("FAIL timeout: dat=%h stb_cycles=%0d lat=%0d bad=%0d required BADC0FFE/%0d/%0d/0",
               rd, sn, lat, sb, TMO_CYC, TMO_CYC + 2);
    end
    xfer(32'h3000_0000, 1'b0, 32'h0, -1, rd, lat, sn, sb);
    checks++;
    if (rd !== model_stat(2'd0) || rd[1:0] !== 2'b10) begin
      errors++;
      $display("FAIL timeout_flags: dat=%h required %h", rd, model_stat(2'd0));
    end
    xfer(32'h3000_0000, 1'b1, $urandom, -1, rd, lat, sn, sb);
    m_cnt = '0; m_flags = '0;
    checks++;
    if (err_irq_o !== 1'b0 || rd !== 32'h0 || lat != 2) begin
      errors++;
      $display("FAIL stat_clear: irq=%b dat=%h lat=%0d required 0/0/2", err_irq_o, rd, lat);
    end
    xfer(32'h3000_0000, 1'b0, 32'h0, -1, rd, lat, sn, sb);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL stat_after_clear: dat=%h required 0", rd);
    end
  endtask

  task automatic test_ack_at_timeout();
    logic [31:0] rd; int lat, sn; bit sb;
    slv_delay[2] = TMO_CYC - 1; slv_data[2] = $urandom;
    xfer(slave_adr(2, 12'h40), 1'b0, 32'h0, 2, rd, lat, sn, sb);
    checks++;
    if (rd !== slv_data[2] || sn != TMO_CYC || lat != TMO_CYC + 2) begin
      errors++;
      $display("FAIL ack_at_timeout: dat=%h stb_cycles=%0d lat=%0d required %h/%0d/%0d",
               rd, sn, lat, slv_data[2], TMO_CYC, TMO_CYC + 2);
    end
    xfer(32'h3000_0000, 1'b0, 32'h0, -1, rd, lat, sn, sb);
    checks++;
    if (rd !== model_stat(2'd0)) begin
      errors++;
      $display("FAIL ack_at_timeout_cnt: dat=%h required %h", rd, model_stat(2'd0));
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd; int lat, sn; bit sb;
    slv_delay[4] = NEVER;
    wbs_adr_i = slave_adr(4, 12'h8); wbs_we_i = 1'b0; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    repeat (3) @(posedge wb_clk_i);
    #1;
    checks++;
    if (s_stb_o !== 8'h10) begin
      errors++;
      $display("FAIL abort_busy_stb: s_stb_o=%b required 00010000", s_stb_o);
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    checks++;
    if (s_stb_o !== '0) begin
      errors++;
      $display("FAIL abort_stb_drop: s_stb_o=%b required 0", s_stb_o);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wbs_ack_o !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_ack: ack=%b required 0 (cycle %0d)", wbs_ack_o, i);
      end
      @(negedge wb_clk_i);
    end
    @(posedge wb_clk_i); #1;
    slv_delay[0] = 0; slv_data[0] = 32'hA5A5_0000;
    xfer(slave_adr(0, 12'h0), 1'b0, 32'h0, 0, rd, lat, sn, sb);
    checks++;
    if (rd !== 32'hA5A5_0000 || lat != 3) begin
      errors++;
      $display("FAIL abort_then_idle: dat=%h lat=%0d required A5A50000/3", rd, lat);
    end
    xfer(32'h3000_0000, 1'b0, 32'h0, -1, rd, lat, sn, sb);
    checks++;
    if (rd !== model_stat(2'd0)) begin
      errors++;
      $display("FAIL abort_no_error: dat=%h required %h", rd, model_stat(2'd0));
    end
  endtask

  task automatic test_stray_ack();
    logic [31:0] rd; int lat, sn; bit sb;
    stray_mask = 8'h20;
    repeat (4) begin
      @(negedge wb_clk_i);
      checks++;
      if (wbs_ack_o !== 1'b0 || s_stb_o !== '0) begin
        errors++;
        $display("FAIL stray_idle: ack=%b stb=%b required 0/0", wbs_ack_o, s_stb_o);
      end
    end
    @(posedge wb_clk_i); #1;
    slv_delay[0] = 2; slv_data[0] = 32'h0BAD_F00D ^ $urandom;
    xfer(slave_adr(0, 12'h124), 1'b0, 32'h0, 0, rd, lat, sn, sb);
    stray_mask = '0;
    checks++;
    if (rd !== slv_data[0] || lat != 5 || sn != 3 || sb) begin
      errors++;
      $display("FAIL stray_busy: dat=%h lat=%0d stb_cycles=%0d bad=%0d required %h/5/3/0",
               rd, lat, sn, sb, slv_data[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; int lat, sn; bit sb;
    for (int k = 0; k < NSLV; k++) begin
      slv_delay[k] = 0;
      slv_data[k]  = $urandom;
    end
    for (int k = 0; k < NSLV; k++) begin
      xfer(slave_adr(k, 12'($urandom)), 1'b0, 32'h0, k, rd, lat, sn, sb);
      checks++;
      if (rd !== slv_data[k] || lat != 3 || sn != 1 || sb) begin
        errors++;
        $display("FAIL b2b_slave%0d: dat=%h lat=%0d stb=%0d/%0d required %h/3/1/0",
                 k, rd, lat, sn, sb, slv_data[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, exp_d; int lat, sn, exp_lat, exp_sn, kind, k, sidx; bit sb; logic w;
    logic [1:0] off;
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 9);
      w    = 1'($urandom_range(0, 1));
      sidx = -1;
      if (kind <= 4) begin
        k = $urandom_range(0, NSLV - 1);
        sidx = k;
        slv_delay[k] = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 6);
        slv_data[k]  = $urandom;
        a = slave_adr(k, 12'($urandom));
        if (slv_delay[k] < TMO_CYC) begin
          exp_d = w ? 32'h0 : slv_data[k]; exp_lat = 3 + slv_delay[k]; exp_sn = slv_delay[k] + 1;
        end else begin
          exp_d = w ? 32'h0 : 32'hBADC_0FFE; exp_lat = TMO_CYC + 2; exp_sn = TMO_CYC;
          m_flags[1] = 1'b1; model_log(a);
        end
      end else if (kind <= 6) begin
        a = {20'h30009 + 20'($urandom_range(0, 4000)), 12'($urandom)};
        exp_d = w ? 32'h0 : 32'hDEAD_0ADD; exp_lat = 2; exp_sn = 0;
        m_flags[0] = 1'b1; model_log(a);
      end else begin
        off = 2'($urandom_range(0, 3));
        if (kind == 8) w = 1'b0;
        a = {STAT_PAGE, 8'($urandom), off, 2'b00};
        exp_d = w ? 32'h0 : model_stat(off); exp_lat = 2; exp_sn = 0;
        if (w && off == 2'd0) begin m_cnt = '0; m_flags = '0; end
      end
      xfer(a, w, $urandom, sidx, rd, lat, sn, sb);
      checks++;
      if (rd !== exp_d || lat != exp_lat || sn != exp_sn || sb) begin
        errors++;
        $display("FAIL random_%0d: adr=%h we=%b dat=%h lat=%0d stb=%0d/%0d required %h/%0d/%0d/0",
                 it, a, w, rd, lat, sn, sb, exp_d, exp_lat, exp_sn);
      end
      checks++;
      if (err_irq_o !== (m_cnt != 16'd0)) begin
        errors++;
        $display("FAIL random_irq_%0d: err_irq_o=%b required %b", it, err_irq_o, (m_cnt != 16'd0));
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NSLV; k++) begin
      slv_delay[k] = 0;
      slv_data[k]  = '0;
      slv_cnt[k]   = 0;
    end
    m_cnt = '0; m_flags = '0; m_addr = '0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    test_reset();
    wb_rst_n_i = 1'b1;
    @(posedge wb_clk_i); #1;
    test_reset();
    test_slave_read();
    test_unmapped();
    test_reset_mid_busy();
    test_timeout();
    test_ack_at_timeout();
    test_abort();
    test_stray_ack();
    test_back_to_back();
    test_random();
    repeat (2) @(posedge wb_clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
